// File: rtl/logic_serial_arbiter.sv
// -----------------------------------------------------------------------------
// logic_serial_arbiter
//
// Shares one 1-bit logic unit between two requesters. A round-robin arbiter
// picks a requester, the winner's W-bit operands are latched and pushed through
// the logic unit one bit per cycle (LSB first), and the assembled W-bit result
// is returned on a valid/ready channel tagged with the requester ID.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   reqN_valid    requester N has an operation pending
//   reqN_ready    requester N is granted (combinational, only in IDLE)
//   reqN_a/b      requester N operands (W bits)
//   reqN_control  requester N op: 0=AND, 1=OR, 2=NOR, 3=XOR
//   result_valid  result/result_id are valid
//   result_ready  consumer accepts the result
//   result        W-bit result, bit i = f(A[i], B[i])
//   result_id     requester that produced the result
// -----------------------------------------------------------------------------
module logic_serial_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_control,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_control,
    output logic         result_valid,
    input  logic         result_ready,
    output logic [W-1:0] result,
    output logic         result_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(W) + 1;

    state_t         state;
    logic           last_grant;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   acc;
    logic [1:0]     ctl;
    logic [CW-1:0]  cnt;

    logic           any_valid;
    logic           grant;
    logic           handshake;
    logic           bit_out;
    logic [W-1:0]   acc_next;

    // Grant depends only on the present valids; nothing about a withdrawn
    // request is remembered.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        any_valid = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && any_valid) begin
            req0_ready = ~grant;
            req1_ready = grant;
        end
    end

    assign handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // One-bit logic unit plus the accumulator shift: the new bit enters at the
    // MSB so that after W shifts the first computed bit sits at bit 0.
    always_comb begin
        bit_out = 1'b0;
        case (ctl)
            2'd0:    bit_out = a_sh[0] & b_sh[0];
            2'd1:    bit_out = a_sh[0] | b_sh[0];
            2'd2:    bit_out = ~(a_sh[0] | b_sh[0]);
            default: bit_out = a_sh[0] ^ b_sh[0];
        endcase
        acc_next        = acc >> 1;
        acc_next[W-1]   = bit_out;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            a_sh         <= '0;
            b_sh         <= '0;
            acc          <= '0;
            ctl          <= 2'd0;
            cnt          <= '0;
            result       <= '0;
            result_id    <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_sh       <= grant ? req1_a       : req0_a;
                        b_sh       <= grant ? req1_b       : req0_b;
                        ctl        <= grant ? req1_control : req0_control;
                        result_id  <= grant;
                        last_grant <= grant;
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    acc  <= acc_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        result       <= acc_next;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // No grant on the consume edge; the next handshake can
                    // only happen once IDLE has been re-entered.
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_serial_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_serial_arbiter
//
// Self-checking bench. Each cycle inputs are driven on the falling edge, the
// outputs are compared against a transaction-level model (whole-word logic
// ops, a countdown for the serial latency), and the model then advances to
// what the next rising edge must produce. Directed sequences add literal
// expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_logic_serial_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_control, req1_control;
    logic         result_valid, result_ready;
    logic [W-1:0] result;
    logic         result_id;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    bit           m_done;
    int           m_wait;     // edges left until the result appears; 0 = not running
    bit           m_last;
    logic [W-1:0] m_res;
    logic [W-1:0] m_pending;
    bit           m_id;

    int grant_log[$];

    logic_serial_arbiter #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_control (req0_control),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_control (req1_control),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .result_id    (result_id)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] op_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] c);
        case (c)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_done = 1'b0;
        m_wait = 0;
        m_last = 1'b1;
        m_res  = '0;
        m_id   = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cycle(input logic rst,
                         input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [1:0] c0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [1:0] c1,
                         input logic rr);
        bit idle;
        bit g;
        @(negedge clk);
        reset        = rst;
        req0_valid   = v0;
        req0_a       = a0;
        req0_b       = b0;
        req0_control = c0;
        req1_valid   = v1;
        req1_a       = a1;
        req1_b       = b1;
        req1_control = c1;
        result_ready = rr;
        #1;
        if (!rst) model_reset();
        idle = !m_done && (m_wait == 0);
        g    = (v0 && v1) ? ~m_last : v1;
        check("result_valid", result_valid, m_done);
        check("result",       result,       m_res);
        check("result_id",    result_id,    m_id);
        check("req0_ready",   req0_ready,   idle && (v0 || v1) && !g);
        check("req1_ready",   req1_ready,   idle && (v0 || v1) && g);
        check("ready_excl",   req0_ready && req1_ready, 1'b0);
        if (req0_valid && req0_ready) grant_log.push_back(0);
        if (req1_valid && req1_ready) grant_log.push_back(1);
        if (rst) begin
            if (m_done) begin
                if (rr) m_done = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pending;
                end
            end else if (v0 || v1) begin
                m_pending = g ? op_word(a1, b1, c1) : op_word(a0, b0, c0);
                m_id      = g;
                m_last    = g;
                m_wait    = W;
            end
        end
    endtask

    task automatic idle_cycle(input logic rr);
        cycle(1'b1, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, rr);
    endtask

    // Single req0 operation with the consumer always ready; pins the literal result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] c,
                          input logic [W-1:0] exp, input string nm);
        cycle(1'b1, 1'b1, a, b, c, 1'b0, '0, '0, 2'd0, 1'b1);
        check({nm, "_ready_idle"}, req0_ready, 1'b1);
        repeat (W) idle_cycle(1'b1);
        idle_cycle(1'b1);
        check({nm, "_valid"}, result_valid, 1'b1);
        check({nm, "_value"}, result, exp);
        check({nm, "_id"}, result_id, 1'b0);
        idle_cycle(1'b1);
        check({nm, "_back_idle"}, result_valid, 1'b0);
        check({nm, "_kept"}, result, exp);
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_control = '0;
        req1_a = '0; req1_b = '0; req1_control = '0;
        result_ready = 1'b0;
        model_reset();

        cycle(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b0);
        check("reset_result", result, 4'b0000);
        check("reset_valid", result_valid, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b0);

        // The four ops on a=1100 b=1010
        run_op(4'b1100, 4'b1010, 2'd0, 4'b1000, "and");
        run_op(4'b1100, 4'b1010, 2'd1, 4'b1110, "or");
        run_op(4'b1100, 4'b1010, 2'd2, 4'b0001, "nor");
        run_op(4'b1100, 4'b1010, 2'd3, 4'b0110, "xor");

        // Round-robin with both requesters continuously valid from reset
        cycle(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
        grant_log.delete();
        for (int i = 0; i < 4 * (W + 2); i++) begin
            cycle(1'b1, 1'b1, 4'b1100, 4'b1010, 2'd0, 1'b1, 4'b1111, 4'b0101, 2'd3, 1'b1);
            if (result_valid && result_id) check("rr_req1_result", result, 4'b1010);
            if (result_valid && !result_id) check("rr_req0_result", result, 4'b1000);
        end
        check("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) check("grant_order", grant_log[i], i % 2);
        end

        // Consumer stalls for 3 cycles in DONE
        cycle(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
        cycle(1'b1, 1'b1, 4'b1100, 4'b1010, 2'd0, 1'b0, '0, '0, 2'd0, 1'b0);
        repeat (W) idle_cycle(1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 4'b0011, 4'b0011, 2'd1, 1'b1, 4'b0001, 4'b0010, 2'd1, 1'b0);
            check("stall_valid", result_valid, 1'b1);
            check("stall_result", result, 4'b1000);
            check("stall_id", result_id, 1'b0);
            check("stall_ready0", req0_ready, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Operand changes during RUN are ignored
        cycle(1'b1, 1'b1, 4'b1100, 4'b1010, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
        repeat (W) cycle(1'b1, 1'b1, 4'b0000, 4'b1010, 2'd3, 1'b0, '0, '0, 2'd0, 1'b1);
        idle_cycle(1'b1);
        check("run_change_result", result, 4'b1000);
        check("run_change_valid", result_valid, 1'b1);
        idle_cycle(1'b1);

        // Reset in the 2nd RUN cycle aborts the operation
        cycle(1'b1, 1'b1, 4'b1100, 4'b1010, 2'd1, 1'b0, '0, '0, 2'd0, 1'b1);
        idle_cycle(1'b1);
        cycle(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, '0, '0, 2'd0, 1'b1);
        check("abort_valid", result_valid, 1'b0);
        check("abort_result", result, 4'b0000);
        idle_cycle(1'b1);
        run_op(4'b1100, 4'b1010, 2'd3, 4'b0110, "after_abort");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(149) != 0,
                  1'($urandom), W'($urandom), W'($urandom), 2'($urandom),
                  1'($urandom), W'($urandom), W'($urandom), 2'($urandom),
                  $urandom_range(3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
